// File: rtl/stim_sequencer.sv
// Plaintext stimulus sequencer: generates pattern blocks, issues them to an AES core, mirrors them and the results into FIFOs.
// Latency: first core_next one cycle after start; plaintext/result visible on the FIFO heads the cycle after the push.
// Backpressure: issue waits for core_ready, no block in flight, plaintext FIFO space and reserved result FIFO space.
//
// Ports: clk/rst_n; control mode, seed, load_seed, burst_len, start, stop; status busy, done,
// issued_count, err_stray; core side core_next, core_block, core_ready, core_result(_valid);
// host side data_require/data/data_empty and result_require/result/result_empty.

// Small first-word-fall-through FIFO; pushes when full and pops when empty are ignored.
module stim_fifo #(
  parameter int W  = 128,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  wdat,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic [AW:0]   count
);
  localparam int DEPTH = 1 << AW;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_pop  = pop & (count != '0);
  assign do_push = push & (count != (AW+1)'(DEPTH));
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdat;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

module stim_sequencer #(
  parameter int                DATA_W    = 128,
  parameter int                DATA_AW   = 2,
  parameter int                RES_AW    = 3,
  parameter logic [DATA_W-1:0] SEED      = 128'hab7240f9_c5e0bb5e_ee8e34b6_bb84cfb0,
  parameter logic [DATA_W-1:0] LFSR_TAPS = 128'ha0000014_00000000_00000000_00000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] seed,
  input  logic              load_seed,
  input  logic [15:0]       burst_len,
  input  logic              start,
  input  logic              stop,
  output logic              busy,
  output logic              done,
  output logic [15:0]       issued_count,
  output logic              err_stray,
  output logic              core_next,
  output logic [DATA_W-1:0] core_block,
  input  logic              core_ready,
  input  logic [DATA_W-1:0] core_result,
  input  logic              core_result_valid,
  input  logic              data_require,
  output logic [DATA_W-1:0] data,
  output logic              data_empty,
  input  logic              result_require,
  output logic [DATA_W-1:0] result,
  output logic              result_empty
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;
  typedef enum logic [1:0] {M_LFSR, M_CNT, M_FIXED, M_WALK} mode_e;

  state_e            state_q, state_d;
  mode_e             mode_q;
  logic [15:0]       burst_q;
  logic [DATA_W-1:0] gen_q, gen_d;
  logic              in_flight;
  logic              idle_like;
  logic              issue;
  logic              data_full;
  logic              res_room;
  logic [DATA_AW:0]  data_count;
  logic [RES_AW:0]   res_count;
  logic [15:0]       count_inc;

  assign idle_like = (state_q == IDLE) || (state_q == DONE);
  assign data_full = data_count == (DATA_AW+1)'(1 << DATA_AW);
  // Space is reserved for the in-flight result so the result FIFO can never overflow.
  assign res_room  = ({1'b0, res_count} + (RES_AW+2)'(in_flight)) < (RES_AW+2)'(1 << RES_AW);
  assign issue     = (state_q == RUN) & ~stop & core_ready & ~in_flight & ~data_full & res_room;
  assign count_inc = issued_count + 16'd1;

  assign core_next  = issue;
  assign core_block = gen_q;
  assign busy       = (state_q == RUN) || (state_q == DRAIN);
  assign done       = (state_q == DONE);
  assign data_empty   = (data_count == '0);
  assign result_empty = (res_count == '0);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (start) state_d = RUN;
      RUN: begin
        if (stop) state_d = DRAIN;
        else if (issue && (burst_q != 16'd0) && (count_inc == burst_q)) state_d = DRAIN;
      end
      // A result arriving this cycle empties the pipe, so leave without waiting a cycle.
      DRAIN: if (!in_flight || core_result_valid) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gen_d = gen_q;
    if (idle_like && load_seed) begin
      // Zero is a lock-up state for LFSR and walking-one, so substitute 1.
      if ((seed == '0) && ((mode == 2'(M_LFSR)) || (mode == 2'(M_WALK))))
        gen_d = DATA_W'(1);
      else
        gen_d = seed;
    end else if (issue) begin
      case (mode_q)
        M_LFSR:  gen_d = {gen_q[DATA_W-2:0], ^(gen_q & LFSR_TAPS)};
        M_CNT:   gen_d = gen_q + DATA_W'(1);
        M_FIXED: gen_d = gen_q;
        default: gen_d = {gen_q[DATA_W-2:0], gen_q[DATA_W-1]};
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      gen_q        <= SEED;
      mode_q       <= M_LFSR;
      burst_q      <= '0;
      issued_count <= '0;
      in_flight    <= 1'b0;
      err_stray    <= 1'b0;
    end else begin
      state_q <= state_d;
      gen_q   <= gen_d;
      if (idle_like && start) begin
        mode_q       <= mode_e'(mode);
        burst_q      <= burst_len;
        issued_count <= '0;
      end else if (issue && (issued_count != 16'hFFFF)) begin
        issued_count <= count_inc;
      end
      if (issue) in_flight <= 1'b1;
      else if (core_result_valid) in_flight <= 1'b0;
      if (core_result_valid && !in_flight) err_stray <= 1'b1;
    end
  end

  stim_fifo #(.W(DATA_W), .AW(DATA_AW)) u_data_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (issue),
    .wdat  (gen_q),
    .pop   (data_require),
    .head  (data),
    .count (data_count)
  );

  stim_fifo #(.W(DATA_W), .AW(RES_AW)) u_res_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (core_result_valid),
    .wdat  (core_result),
    .pop   (result_require),
    .head  (result),
    .count (res_count)
  );
endmodule

// File: tb/tb_stim_sequencer.sv
// Bench for stim_sequencer: core model with fixed latency, plaintext/result scoreboards.
module tb_stim_sequencer;
  localparam logic [127:0] SEED  = 128'hab7240f9_c5e0bb5e_ee8e34b6_bb84cfb0;
  localparam logic [127:0] TAPS  = 128'ha0000014_00000000_00000000_00000000;
  localparam logic [127:0] XK    = 128'h01234567_89abcdef_fedcba98_76543210;
  localparam logic [127:0] STRAY = 128'hcafef00d_00000000_11112222_33334444;
  localparam int LAT = 10;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [1:0]   mode = 2'd0;
  logic [127:0] seed = '0;
  logic         load_seed = 1'b0;
  logic [15:0]  burst_len = '0;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic         busy, done, err_stray, core_next, data_empty, result_empty;
  logic [15:0]  issued_count;
  logic [127:0] core_block, data, result, core_result;
  logic         core_ready = 1'b1;
  logic         core_result_valid;
  logic         data_require = 1'b0;
  logic         result_require = 1'b0;

  logic         mdl_vld = 1'b0;
  logic [127:0] mdl_res = '0;
  logic         stray_vld = 1'b0;
  int           pend = 0;
  logic [127:0] pend_blk = '0;

  logic [127:0] exp_data[$];
  logic [127:0] exp_res[$];
  logic [127:0] blk_log[$];
  logic [127:0] gm = SEED;
  logic [1:0]   cur_mode = 2'd0;
  int           pulses = 0;
  int           data_pops = 0;
  int           res_pops = 0;
  int           data_pop_req = 0;
  logic         auto_data = 1'b0;
  logic         auto_res = 1'b0;
  int           total = 0;
  int           bad = 0;

  assign core_result_valid = mdl_vld | stray_vld;
  assign core_result       = stray_vld ? STRAY : mdl_res;

  stim_sequencer dut (
    .clk (clk), .rst_n (rst_n), .mode (mode), .seed (seed), .load_seed (load_seed),
    .burst_len (burst_len), .start (start), .stop (stop), .busy (busy), .done (done),
    .issued_count (issued_count), .err_stray (err_stray), .core_next (core_next),
    .core_block (core_block), .core_ready (core_ready), .core_result (core_result),
    .core_result_valid (core_result_valid), .data_require (data_require), .data (data),
    .data_empty (data_empty), .result_require (result_require), .result (result),
    .result_empty (result_empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] xform(input logic [127:0] b);
    return {b[63:0], b[127:64]} ^ XK;
  endfunction

  function automatic logic [127:0] adv(input logic [127:0] s, input logic [1:0] m);
    case (m)
      2'd0:    return {s[126:0], ^(s & TAPS)};
      2'd1:    return s + 128'd1;
      2'd2:    return s;
      default: return {s[126:0], s[127]};
    endcase
  endfunction

  // Core model: sees core_next mid-cycle, answers LAT cycles later, drops ready while busy.
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend = 0; mdl_vld = 1'b0; core_ready = 1'b1;
    end else begin
      mdl_vld = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          mdl_vld = 1'b1;
          mdl_res = xform(pend_blk);
        end
      end
      core_ready = (pend == 0);
      if (core_next) begin
        pulses++;
        chk("core_block", core_block, gm);
        blk_log.push_back(core_block);
        exp_data.push_back(gm);
        exp_res.push_back(xform(gm));
        pend_blk = core_block;
        pend = LAT;
        gm = adv(gm, cur_mode);
      end
    end
  end

  // Host side: pops and scores both FIFOs.
  always @(posedge clk) begin
    #1;
    data_require = 1'b0;
    result_require = 1'b0;
    if (rst_n) begin
      if (!data_empty && (auto_data || data_pop_req > 0)) begin
        if (data_pop_req > 0) data_pop_req--;
        if (exp_data.size() == 0) chk("data_q", 128'(exp_data.size()), 128'd1);
        else chk("data", data, exp_data.pop_front());
        data_pops++;
        data_require = 1'b1;
      end
      if (!result_empty && auto_res) begin
        if (exp_res.size() == 0) chk("res_q", 128'(exp_res.size()), 128'd1);
        else chk("result", result, exp_res.pop_front());
        res_pops++;
        result_require = 1'b1;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic check_reset_vals();
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_done", 128'(done), 128'd0);
    chk("rst_next", 128'(core_next), 128'd0);
    chk("rst_count", 128'(issued_count), 128'd0);
    chk("rst_stray", 128'(err_stray), 128'd0);
    chk("rst_dempty", 128'(data_empty), 128'd1);
    chk("rst_rempty", 128'(result_empty), 128'd1);
    chk("rst_block", core_block, SEED);
    chk("rst_data", data, 128'd0);
    chk("rst_result", result, 128'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    auto_data = 1'b0; auto_res = 1'b0; data_pop_req = 0;
    exp_data.delete(); exp_res.delete();
    gm = SEED;
    step(2);
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic load(input logic [127:0] s, input logic [1:0] m);
    mode = m; seed = s; load_seed = 1'b1;
    gm = (s == '0 && (m == 2'd0 || m == 2'd3)) ? 128'd1 : s;
    step(1);
    load_seed = 1'b0;
    chk("seed_load", core_block, gm);
  endtask

  task automatic start_burst(input logic [1:0] m, input logic [15:0] len);
    mode = m; burst_len = len; cur_mode = m;
    pulses = 0; blk_log.delete();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic stop_pulse();
    stop = 1'b1;
    step(1);
    stop = 1'b0;
  endtask

  task automatic wait_done(input int maxc);
    int n = 0;
    while (!done && n < maxc) begin step(1); n++; end
    chk("done_wait", 128'(done), 128'd1);
  endtask

  task automatic drain_all();
    int n = 0;
    auto_data = 1'b1; auto_res = 1'b1;
    while ((!data_empty || !result_empty || busy) && n < 400) begin step(1); n++; end
    step(2);
    chk("drained", 128'({data_empty, result_empty}), 128'd3);
    auto_data = 1'b0; auto_res = 1'b0;
  endtask

  initial begin
    step(2);
    check_reset_vals();
    rst_n = 1'b1;
    step(1);

    // Counter mode, bounded burst of 3.
    load(128'd1, 2'd1);
    start_burst(2'd1, 16'd3);
    wait_done(200);
    chk("s1_count", 128'(issued_count), 128'd3);
    chk("s1_pulses", 128'(pulses), 128'd3);
    if (blk_log.size() == 3) begin
      chk("s1_blk0", blk_log[0], 128'd1);
      chk("s1_blk1", blk_log[1], 128'd2);
      chk("s1_blk2", blk_log[2], 128'd3);
    end else chk("s1_nblk", 128'(blk_log.size()), 128'd3);
    data_pops = 0; res_pops = 0;
    drain_all();
    chk("s1_dpops", 128'(data_pops), 128'd3);
    chk("s1_rpops", 128'(res_pops), 128'd3);

    // LFSR with zero seed starts from 1.
    load(128'd0, 2'd0);
    start_burst(2'd0, 16'd4);
    chk("s2_done_fall", 128'(done), 128'd0);
    wait_done(200);
    chk("s2_first", blk_log.size() > 0 ? blk_log[0] : 128'hx, 128'd1);
    chk("s2_count", 128'(issued_count), 128'd4);
    drain_all();

    // LFSR feedback: top bit set feeds a 1 into bit 0.
    load(128'h80000000_00000000_00000000_00000001, 2'd0);
    start_burst(2'd0, 16'd2);
    wait_done(200);
    chk("s2b_second", blk_log.size() > 1 ? blk_log[1] : 128'hx, 128'd3);
    drain_all();

    // Unbounded, plaintext not drained: stalls on a full plaintext FIFO.
    load(128'h100, 2'd1);
    auto_res = 1'b1;
    start_burst(2'd1, 16'd0);
    step(100);
    chk("s3_count4", 128'(issued_count), 128'd4);
    chk("s3_pulses4", 128'(pulses), 128'd4);
    data_pop_req = 1;
    step(60);
    chk("s3_count5", 128'(issued_count), 128'd5);
    chk("s3_pulses5", 128'(pulses), 128'd5);
    stop_pulse();
    wait_done(100);
    drain_all();

    // Unbounded, results not drained: at most 8 results, none lost.
    load(128'h5a5a, 2'd2);
    auto_data = 1'b1;
    start_burst(2'd2, 16'd0);
    step(200);
    chk("s4_pulses8", 128'(pulses), 128'd8);
    chk("s4_rempty", 128'(result_empty), 128'd0);
    step(40);
    chk("s4_held", 128'(pulses), 128'd8);
    stop_pulse();
    wait_done(50);
    res_pops = 0;
    drain_all();
    chk("s4_rpops", 128'(res_pops), 128'd8);

    // Stop with a block in flight.
    load(128'd0, 2'd3);
    auto_data = 1'b1; auto_res = 1'b1;
    start_burst(2'd3, 16'd0);
    begin
      int n = 0;
      while (pulses == 0 && n < 50) begin step(1); n++; end
    end
    step(3);
    stop_pulse();
    chk("s5_busy", 128'(busy), 128'd1);
    step(4);
    chk("s5_drain", 128'({busy, done}), 128'd2);
    wait_done(50);
    chk("s5_pulses", 128'(pulses), 128'd1);
    drain_all();

    // Stray result in IDLE.
    do_reset();
    exp_res.push_back(STRAY);
    stray_vld = 1'b1;
    step(1);
    stray_vld = 1'b0;
    chk("s6_stray", 128'(err_stray), 128'd1);
    res_pops = 0;
    drain_all();
    chk("s6_rpops", 128'(res_pops), 128'd1);
    step(5);
    chk("s6_sticky", 128'(err_stray), 128'd1);

    // Reset in the middle of a burst.
    load(128'd7, 2'd1);
    auto_data = 1'b1; auto_res = 1'b1;
    start_burst(2'd1, 16'd0);
    begin
      int n = 0;
      while (pulses < 2 && n < 100) begin step(1); n++; end
    end
    step(3);
    rst_n = 1'b0;
    #1;
    check_reset_vals();
    do_reset();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
